// File: rtl/yadmc_dpram_burst_ctrl.sv
// yadmc_dpram_burst_ctrl: burst sequencer for one yadmc_dpram port, 2-entry read buffer.
// Define YADMC_BURST_WRAP_EN for wrapping (critical-word-first) bursts.
module yadmc_dpram_burst_ctrl #(
  parameter int ADDRESS_DEPTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDRESS_DEPTH-1:0] cmd_adr,
  input  logic [LEN_WIDTH-1:0]     cmd_len,
  input  logic                     wd_valid,
  output logic                     wd_ready,
  input  logic [DATA_WIDTH-1:0]    wd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_DEPTH-1:0] ram_adr,
  output logic                     ram_we,
  output logic [DATA_WIDTH-1:0]    ram_di,
  input  logic [DATA_WIDTH-1:0]    ram_do
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
  state_t state, state_nxt;
  logic [ADDRESS_DEPTH-1:0] cur, cur_inc;
  logic [LEN_WIDTH-1:0] rem;
  logic [1:0] occ;
  logic [2:0] fill;
  logic pend, wr_beat, issue, pop, last_pop;
  logic [DATA_WIDTH-1:0] buf1;
`ifdef YADMC_BURST_WRAP_EN
  assign cur_inc = {cur[ADDRESS_DEPTH-1:LEN_WIDTH], cur[LEN_WIDTH-1:0] + LEN_WIDTH'(1)};
`else
  assign cur_inc = cur + ADDRESS_DEPTH'(1);
`endif
  assign cmd_ready = state == IDLE;
  assign wd_ready = state == WRITE;
  assign busy = state != IDLE;
  assign rd_valid = occ != 2'd0;
  assign pop = rd_valid & rd_ready;
  assign wr_beat = wd_ready & wd_valid;
  // a pop this cycle frees a slot, so issuing keeps up with a sustained consumer
  assign fill = 3'(occ) + 3'(pend) - 3'(pop);
  assign issue = state == READ && fill < 3'd2;
  assign last_pop = state == DRAIN && !pend && occ == 2'd1 && pop;
  assign ram_we = wr_beat;
  assign ram_adr = cur;
  assign ram_di = wr_beat ? wd_data : '0;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = cmd_valid ? (cmd_write ? WRITE : READ) : IDLE;
      WRITE: state_nxt = (wr_beat && rem == '0) ? IDLE : WRITE;
      READ:  state_nxt = (issue && rem == '0) ? DRAIN : READ;
      DRAIN: state_nxt = (!pend && (occ == 2'd0 || last_pop)) ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cur <= '0;
      rem <= '0;
      occ <= 2'd0;
      pend <= 1'b0;
      rd_data <= '0;
      buf1 <= '0;
      done <= 1'b0;
    end else begin
      state <= state_nxt;
      done <= (wr_beat && rem == '0) || last_pop;
      pend <= issue;
      occ <= occ + 2'(pend) - 2'(pop);
      if (state == IDLE && cmd_valid) begin
        cur <= cmd_adr;
        rem <= cmd_len;
      end else if (wr_beat || issue) begin
        cur <= cur_inc;
        rem <= rem - 1'b1;
      end
      if (pop && occ == 2'd2)
        rd_data <= buf1;
      else if (pend && (occ == 2'd0 || (occ == 2'd1 && pop)))
        rd_data <= ram_do;
      if (pend && ((occ == 2'd1 && !pop) || (occ == 2'd2 && pop)))
        buf1 <= ram_do;
    end
  end
endmodule

// File: tb/tb_yadmc_dpram_burst_ctrl.sv
// tb_yadmc_dpram_burst_ctrl: directed bench for the burst sequencer with a sync-read RAM model.
module tb_yadmc_dpram_burst_ctrl;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [9:0] cmd_adr = '0;
  logic [3:0] cmd_len = '0;
  logic wd_valid = 0, wd_ready;
  logic [7:0] wd_data = '0;
  logic rd_valid, rd_ready = 0;
  logic [7:0] rd_data;
  logic busy, done, ram_we;
  logic [9:0] ram_adr;
  logic [7:0] ram_di, ram_do;
  logic [7:0] mem [0:1023];
  int n_cmp = 0, n_bad = 0;

  yadmc_dpram_burst_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_adr(cmd_adr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done), .ram_adr(ram_adr), .ram_we(ram_we),
    .ram_di(ram_di), .ram_do(ram_do)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_adr] <= ram_di;
    ram_do <= mem[ram_adr];
  end

  function automatic [9:0] exp_adr(input [9:0] a, input int i);
`ifdef YADMC_BURST_WRAP_EN
    return {a[9:4], a[3:0] + i[3:0]};
`else
    return a + i[9:0];
`endif
  endfunction

  task automatic test_reset;
    rst_n = 0;
    @(negedge clk);
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
    n_cmp++; if (wd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_wd_ready got %b exp 0", wd_ready); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    n_cmp++; if (rd_data !== 8'h00) begin n_bad++; $display("FAIL reset_rd_data got %h exp 00", rd_data); end
    n_cmp++; if ({busy, done, ram_we} !== 3'b000) begin n_bad++; $display("FAIL reset_busy_done_we got %b exp 000", {busy, done, ram_we}); end
    n_cmp++; if ({ram_adr, ram_di} !== 18'h0) begin n_bad++; $display("FAIL reset_ram got %h/%h exp 0/0", ram_adr, ram_di); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic write_burst(input [9:0] adr, input [3:0] len, input [7:0] d0, input bit gaps);
    int k = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_adr = adr; cmd_len = len;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL wr_cmd_ready got %b exp 1", cmd_ready); end
    for (int j = 1; j < 64 && k <= int'(len); j++) begin
      @(negedge clk);
      cmd_valid = 0;
      wd_valid = gaps ? j[0] : 1'b1;
      wd_data = d0 + 8'(k);
      #1;
      n_cmp++; if (ram_we !== wd_valid) begin n_bad++; $display("FAIL wr_we cyc %0d got %b exp %b", j, ram_we, wd_valid); end
      if (wd_valid) begin
        n_cmp++; if (ram_adr !== exp_adr(adr, k) || ram_di !== d0 + 8'(k)) begin
          n_bad++; $display("FAIL wr_beat %0d got %h/%h exp %h/%h", k, ram_adr, ram_di, exp_adr(adr, k), d0 + 8'(k));
        end
        k++;
      end
    end
    n_cmp++; if (k != int'(len) + 1) begin n_bad++; $display("FAIL wr_timeout beats %0d exp %0d", k, int'(len) + 1); end
    @(negedge clk);
    wd_valid = 0;
    #1;
    n_cmp++; if ({done, busy} !== 2'b10) begin n_bad++; $display("FAIL wr_done_busy got %b exp 10", {done, busy}); end
    @(negedge clk);
    #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL wr_done_pulse got %b exp 0", done); end
  endtask

  task automatic read_burst(input [9:0] adr, input [3:0] len, input [7:0] d0, input bit toggle, input bit chk_lat);
    int k = 0, first = 0, early_done = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 0; cmd_adr = adr; cmd_len = len;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rd_cmd_ready got %b exp 1", cmd_ready); end
    for (int j = 1; j < 200 && k <= int'(len); j++) begin
      @(negedge clk);
      cmd_valid = 0;
      rd_ready = toggle ? j[0] : 1'b1;
      #1;
      if (done) early_done++;
      if (j == 1) begin
        n_cmp++; if (ram_adr !== adr || busy !== 1'b1) begin n_bad++; $display("FAIL rd_first_adr got %h/%b exp %h/1", ram_adr, busy, adr); end
      end
      if (rd_valid && rd_ready) begin
        if (first == 0) first = j;
        n_cmp++; if (rd_data !== d0 + 8'(k)) begin n_bad++; $display("FAIL rd_beat %0d got %h exp %h", k, rd_data, d0 + 8'(k)); end
        k++;
      end
    end
    n_cmp++; if (k != int'(len) + 1) begin n_bad++; $display("FAIL rd_timeout beats %0d exp %0d", k, int'(len) + 1); end
    n_cmp++; if (early_done != 0) begin n_bad++; $display("FAIL rd_early_done got %0d exp 0", early_done); end
    if (chk_lat) begin
      n_cmp++; if (first != 3) begin n_bad++; $display("FAIL rd_latency got N+%0d exp N+3", first); end
    end
    @(negedge clk);
    rd_ready = 0;
    #1;
    n_cmp++; if ({done, busy, rd_valid} !== 3'b100) begin n_bad++; $display("FAIL rd_done_busy_valid got %b exp 100", {done, busy, rd_valid}); end
    @(negedge clk);
    #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rd_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_write;
    write_burst(10'h010, 4'd3, 8'hA0, 1'b0);
  endtask

  task automatic test_read;
    read_burst(10'h010, 4'd3, 8'hA0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure;
    write_burst(10'h100, 4'd7, 8'hB0, 1'b0);
    read_burst(10'h100, 4'd7, 8'hB0, 1'b1, 1'b0);
  endtask

  task automatic test_wrap;
`ifdef YADMC_BURST_WRAP_EN
    write_burst(10'h01E, 4'd3, 8'hC0, 1'b0);
    read_burst(10'h01E, 4'd3, 8'hC0, 1'b0, 1'b1);
`else
    write_burst(10'h3FE, 4'd3, 8'hC0, 1'b0);
    read_burst(10'h3FE, 4'd3, 8'hC0, 1'b0, 1'b1);
`endif
  endtask

  task automatic test_reset_mid_burst;
    int k = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 0; cmd_adr = 10'h100; cmd_len = 4'd7;
    for (int j = 0; j < 20 && k < 2; j++) begin
      @(negedge clk);
      cmd_valid = 0;
      rd_ready = 1;
      #1;
      if (rd_valid) k++;
    end
    @(negedge clk);
    rd_ready = 0;
    rst_n = 0;
    #1;
    n_cmp++; if ({rd_valid, busy, cmd_ready, ram_we} !== 4'b0010) begin n_bad++; $display("FAIL rst_mid_ctrl got %b exp 0010", {rd_valid, busy, cmd_ready, ram_we}); end
    n_cmp++; if (rd_data !== 8'h00 || ram_adr !== 10'h000) begin n_bad++; $display("FAIL rst_mid_data got %h/%h exp 00/000", rd_data, ram_adr); end
    @(negedge clk);
    #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_mid_done got %b exp 0", done); end
    rst_n = 1;
    read_burst(10'h100, 4'd3, 8'hB0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back;
    int k = 0, seen = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_adr = 10'h200; cmd_len = 4'd3;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_cmd1_ready got %b exp 1", cmd_ready); end
    for (int j = 1; j < 40 && k < 4; j++) begin
      @(negedge clk);
      cmd_write = 0; cmd_adr = 10'h100; cmd_len = 4'd0;
      wd_valid = j[0];
      wd_data = 8'hD0 + 8'(k);
      #1;
      n_cmp++; if (cmd_ready !== 1'b0 || ram_we !== wd_valid) begin n_bad++; $display("FAIL b2b_busy cyc %0d got ready=%b we=%b exp ready=0 we=%b", j, cmd_ready, ram_we, wd_valid); end
      if (wd_valid) begin
        n_cmp++; if (ram_adr !== 10'h200 + 10'(k)) begin n_bad++; $display("FAIL b2b_adr %0d got %h exp %h", k, ram_adr, 10'h200 + 10'(k)); end
        k++;
      end
    end
    @(negedge clk);
    wd_valid = 0;
    rd_ready = 1;
    #1;
    n_cmp++; if ({cmd_ready, done} !== 2'b11) begin n_bad++; $display("FAIL b2b_idle got ready,done=%b exp 11", {cmd_ready, done}); end
    @(negedge clk);
    cmd_valid = 0;
    #1;
    n_cmp++; if (busy !== 1'b1 || ram_adr !== 10'h100 || wd_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_cmd2 got busy=%b adr=%h wd_ready=%b exp 1/100/0", busy, ram_adr, wd_ready); end
    for (int j = 0; j < 10 && seen == 0; j++) begin
      @(negedge clk);
      #1;
      if (rd_valid) seen = 1;
    end
    n_cmp++; if (seen != 1 || rd_data !== 8'hB0) begin n_bad++; $display("FAIL b2b_rd got seen=%0d data=%h exp 1/b0", seen, rd_data); end
    @(negedge clk);
    rd_ready = 0;
    #1;
    n_cmp++; if ({done, busy} !== 2'b10) begin n_bad++; $display("FAIL b2b_rd_done got %b exp 10", {done, busy}); end
    read_burst(10'h200, 4'd3, 8'hD0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_backpressure;
    test_wrap;
    test_reset_mid_burst;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
